// File: rtl/hilo_unit_if.sv
// HI/LO unit pipeline-side bundle: issue/access requests in, read data and status out.
// Latency: none (signal grouping only).
// Backpressure: stall is returned through the slave modport and honoured by the master.
interface hilo_unit_if;
  logic [3:0]  op;
  logic        md_start;
  logic [31:0] alu_r1;
  logic [31:0] alu_r2;
  logic [31:0] x;
  logic [31:0] y;
  logic        mthi;
  logic        mtlo;
  logic        mfhi;
  logic        mflo;
  logic [31:0] rdata;
  logic        busy;
  logic        stall;
  logic        div0;

  // Pipeline (EX stage) side
  modport master (
    output op, md_start, alu_r1, alu_r2, x, y, mthi, mtlo, mfhi, mflo,
    input  rdata, busy, stall, div0
  );

  // HI/LO unit side
  modport slave (
    input  op, md_start, alu_r1, alu_r2, x, y, mthi, mtlo, mfhi, mflo,
    output rdata, busy, stall, div0
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register pair with multi-cycle mul/div commit timing and mfhi/mflo/mthi/mtlo access.
// Latency: mul/div commit MUL_LAT/DIV_LAT edges after issue; mt writes at the edge; mf reads combinational.
// Backpressure: stall asserted while busy if any access or new mul/div is requested; stalled requests are dropped.
module hilo_unit #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  hilo_unit_if.slave  bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [3:0] OP_MUL = 4'h3;
  localparam logic [3:0] OP_DIV = 4'h4;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [31:0]     hi, hi_n;
  logic [31:0]     lo, lo_n;
  logic [31:0]     pend_hi, pend_hi_n;
  logic [31:0]     pend_lo, pend_lo_n;
  logic            div0, div0_n;

  logic            req_any;

  assign req_any   = bus.md_start | bus.mthi | bus.mtlo | bus.mfhi | bus.mflo;
  assign bus.busy  = (state == BUSY);
  assign bus.stall = bus.busy & req_any;
  assign bus.div0  = div0;
  assign bus.rdata = bus.mfhi ? hi : (bus.mflo ? lo : 32'h0);

  // State and datapath registers; reset discards any in-flight result
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      div0    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      hi      <= hi_n;
      lo      <= lo_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
      div0    <= div0_n;
    end
  end

  // Next-state: issue captures operands, countdown, commit; mt writes only when idle
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hi_n      = hi;
    lo_n      = lo;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    div0_n    = div0;

    unique case (state)
      IDLE: begin
        if (bus.md_start) begin
          // md_start owns the cycle; an accompanying mt write is dropped
          if (bus.op == OP_MUL) begin
            pend_hi_n = bus.alu_r2;
            pend_lo_n = bus.alu_r1;
            cnt_n     = CW'(MUL_LAT - 1);
            state_n   = BUSY;
          end else if (bus.op == OP_DIV) begin
            if (bus.y == 32'h0) begin
              // Divide by zero: HI gets the dividend, LO all ones
              pend_hi_n = bus.x;
              pend_lo_n = 32'hFFFF_FFFF;
              div0_n    = 1'b1;
            end else begin
              pend_hi_n = bus.alu_r2;
              pend_lo_n = bus.alu_r1;
            end
            cnt_n   = CW'(DIV_LAT - 1);
            state_n = BUSY;
          end
        end else begin
          if (bus.mthi) hi_n = bus.x;
          if (bus.mtlo) lo_n = bus.x;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else begin
          hi_n    = pend_hi;
          lo_n    = pend_lo;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: scoreboard of expected read data plus status checks.
// Latency: inputs driven #1 after posedge, outputs sampled on negedge.
// Backpressure: bench holds requests while stall is expected and verifies they have no effect.
module tb_hilo_unit;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hilo_unit_if bus ();

  hilo_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.op = 4'h0; bus.md_start = 1'b0;
    bus.alu_r1 = '0; bus.alu_r2 = '0; bus.x = '0; bus.y = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.mfhi = 1'b0; bus.mflo = 1'b0;
  endtask

  // Read while idle: expectation queued at drive, popped when rdata is sampled
  task automatic read_reg(input string tag, input bit rd_hi, input bit rd_lo, input logic [31:0] exp);
    bus.mfhi = rd_hi;
    bus.mflo = rd_lo;
    exp_q.push_back(exp);
    @(negedge clk);
    check({tag, "_stall"}, 32'(bus.stall), 32'h0);
    check(tag, bus.rdata, exp_q.pop_front());
    next_cycle;
    bus.mfhi = 1'b0;
    bus.mflo = 1'b0;
  endtask

  // Issue a mul/div while idle; scramble operands afterwards to prove capture-at-issue
  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] r1, input logic [31:0] r2);
    bus.op = op; bus.md_start = 1'b1;
    bus.x = x; bus.y = y; bus.alu_r1 = r1; bus.alu_r2 = r2;
    @(negedge clk);
    check("issue_stall", 32'(bus.stall), 32'h0);
    next_cycle;
    bus.md_start = 1'b0;
    bus.x = $urandom; bus.y = $urandom; bus.alu_r1 = $urandom; bus.alu_r2 = $urandom;
  endtask

  // Count busy cycles until idle; returns at the negedge of the first idle cycle
  task automatic wait_idle(input string tag, input bit stall_exp, output int n);
    int i;
    n = 0;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
      if (stall_exp) check({tag, "_stall_busy"}, 32'(bus.stall), 32'h1);
      next_cycle;
    end
    if (i == 200) check({tag, "_timeout"}, 32'h1, 32'h0);
  endtask

  initial begin
    int n;
    idle_inputs();
    rst = 1'b1;
    next_cycle;
    next_cycle;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_div0", 32'(bus.div0), 32'h0);
    next_cycle;
    read_reg("rst_hi", 1'b1, 1'b0, 32'h0);
    read_reg("rst_lo", 1'b0, 1'b1, 32'h0);

    // Multiply: mfhi held every cycle, stalled until commit
    issue(4'h3, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h1);
    bus.mfhi = 1'b1;
    exp_q.push_back(32'h1);
    wait_idle("mul", 1'b1, n);
    check("mul_lat", n, MUL_LAT);
    check("mul_stall_after", 32'(bus.stall), 32'h0);
    check("mul_hi", bus.rdata, exp_q.pop_front());
    next_cycle;
    bus.mfhi = 1'b0;
    read_reg("mul_lo", 1'b0, 1'b1, 32'h0);

    // Divide 100/7 with a re-issue and mthi attempted while busy
    issue(4'h4, 32'd100, 32'd7, 32'd14, 32'd2);
    bus.md_start = 1'b1; bus.op = 4'h3; bus.mthi = 1'b1; bus.x = 32'h55;
    bus.alu_r1 = 32'd99; bus.alu_r2 = 32'd99;
    @(negedge clk);
    check("div_reissue_stall", 32'(bus.stall), 32'h1);
    check("div_busy", 32'(bus.busy), 32'h1);
    next_cycle;
    bus.md_start = 1'b0; bus.mthi = 1'b0;
    wait_idle("div", 1'b0, n);
    check("div_lat", n, DIV_LAT - 1);
    next_cycle;
    read_reg("div_hi", 1'b1, 1'b0, 32'd2);
    read_reg("div_lo", 1'b0, 1'b1, 32'd14);
    read_reg("div_prio", 1'b1, 1'b1, 32'd2);
    check("div_div0", 32'(bus.div0), 32'h0);

    // Divide by zero
    issue(4'h4, 32'h1234_5678, 32'h0, 32'hDEAD, 32'hBEEF);
    @(negedge clk);
    check("div0_set", 32'(bus.div0), 32'h1);
    next_cycle;
    wait_idle("div0", 1'b0, n);
    check("div0_lat", n, DIV_LAT - 1);
    check("div0_sticky", 32'(bus.div0), 32'h1);
    next_cycle;
    read_reg("div0_hi", 1'b1, 1'b0, 32'h1234_5678);
    read_reg("div0_lo", 1'b0, 1'b1, 32'hFFFF_FFFF);

    // Ignored opcode: md_start with op 5 leaves the unit idle
    bus.op = 4'h5; bus.md_start = 1'b1;
    next_cycle;
    bus.md_start = 1'b0;
    @(negedge clk);
    check("badop_busy", 32'(bus.busy), 32'h0);
    next_cycle;

    // mthi + mtlo together, same-cycle mfhi sees the old value
    bus.x = 32'hAAAA_0000; bus.mthi = 1'b1; bus.mtlo = 1'b1;
    read_reg("mt_old", 1'b1, 1'b0, 32'h1234_5678);
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    read_reg("mt_hi", 1'b1, 1'b0, 32'hAAAA_0000);
    read_reg("mt_lo", 1'b0, 1'b1, 32'hAAAA_0000);
    bus.x = 32'h0BAD_F00D; bus.mthi = 1'b1;
    next_cycle;
    bus.mthi = 1'b0;
    read_reg("mthi_only_hi", 1'b1, 1'b0, 32'h0BAD_F00D);
    read_reg("mthi_only_lo", 1'b0, 1'b1, 32'hAAAA_0000);

    // Reset mid-multiply discards the pending result
    issue(4'h3, 32'd5, 32'd6, 32'd30, 32'd0);
    next_cycle;
    rst = 1'b1;
    next_cycle;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_busy", 32'(bus.busy), 32'h0);
    check("rstmid_div0", 32'(bus.div0), 32'h0);
    next_cycle;
    repeat (MUL_LAT + 2) next_cycle;
    read_reg("rstmid_hi", 1'b1, 1'b0, 32'h0);
    read_reg("rstmid_lo", 1'b0, 1'b1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
